// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester onto a UART TX FIFO for a whole burst.
// Latency: one IDLE arbitration cycle before the grant; after that, one write per cycle with no added delay.
// Backpressure: tx_full stalls the lock holder in place and no character is dropped.
//
// Ports:
//   clk, reset          - single clock; synchronous active-high reset
//   req, last, data_in  - per-lane character valid, end-of-burst flag, packed character lanes
//   ack                 - one-hot accept pulse back to the lane whose character was written
//   tx_full             - UART TX FIFO full
//   wr_uart, wr_data    - write strobe and character into the UART TX FIFO
//   owner, busy         - lock holder index and lock-held flag
//   abort               - one-cycle pulse when a stalled lock is force-released
//
// Build option: define UART_ARB_TIMEOUT_EN to release a lock whose holder stops
// requesting for TIMEOUT consecutive cycles. Without it the lock is held until a
// last write, abort is tied low and no stall counter exists.

module uart_tx_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             last,
    input  logic [NUM_REQ*DATA_BITS-1:0]   data_in,
    output logic [NUM_REQ-1:0]             ack,
    input  logic                           tx_full,
    output logic                           wr_uart,
    output logic [DATA_BITS-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           busy,
    output logic                           abort
);

    localparam int OW = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Elaboration-time guards on the legal parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be in 2..255");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
        $error("uart_tx_arbiter: DATA_BITS must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_rr_ptr;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_locked;
    logic                 w_req_own;
    logic                 w_last_own;
    logic                 w_wr;
    logic                 w_release;
    logic [OW-1:0]        w_sel;
    logic [OW-1:0]        w_owner_inc;
    logic [DATA_BITS-1:0] w_wr_data;
    logic [NUM_REQ-1:0]   w_ack;
    logic                 w_timeout;

    assign w_locked   = (r_state == ST_LOCKED);
    assign w_req_own  = req[r_owner];
    assign w_last_own = last[r_owner];

    // The write strobe is gated by reset so that a lock interrupted by reset
    // never produces a write during the reset cycle itself.
    assign w_wr = !reset && w_locked && w_req_own && !tx_full;

    // Next round-robin start point after the current owner gives up the lock.
    assign w_owner_inc = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);

    // First requester at or above r_rr_ptr, wrapping. The loop walks from the
    // farthest candidate down to the nearest so the nearest set bit wins.
    // Modulo is done by a single conditional subtract so NUM_REQ need not be
    // a power of two.
    always_comb begin
        w_sel = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [OW:0] cand;
            cand = {1'b0, r_rr_ptr} + (OW+1)'(k);
            if (cand >= (OW+1)'(NUM_REQ)) begin
                cand = cand - (OW+1)'(NUM_REQ);
            end
            if (req[cand[OW-1:0]]) begin
                w_sel = cand[OW-1:0];
            end
        end
    end

    // Lane mux: wr_data follows the owner's lane every cycle.
    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_wr_data = data_in[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Only the owner's ack bit can ever be set, and only on a write.
    always_comb begin
        w_ack          = '0;
        w_ack[r_owner] = w_wr;
    end

    // ------------------------------------------------------------------
    // Optional stall timeout
    // ------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0] r_stall;

    // Only cycles where the owner has nothing to send and the FIFO could
    // take a character count as stalls; a full FIFO is not the owner's fault.
    logic w_stall_cycle;
    assign w_stall_cycle = w_locked && !w_req_own && !tx_full;

    assign w_timeout = !reset && w_stall_cycle && (r_stall == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (!w_locked || w_timeout) begin
            r_stall <= '0;
        end else if (w_stall_cycle) begin
            r_stall <= r_stall + 8'd1;
        end else begin
            // A write or a full FIFO restarts the stall count.
            r_stall <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Lock ends on a last write, or on a timeout when that option is built.
    assign w_release = (w_wr && w_last_own) || w_timeout;

    // ------------------------------------------------------------------
    // FSM: IDLE arbitrates, LOCKED streams the owner's burst
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_owner <= w_sel;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Returning to IDLE forces one arbitration cycle, so the
                    // releasing owner cannot be re-granted in the same cycle.
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_owner_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all status outputs read as zero while reset is asserted)
    // ------------------------------------------------------------------
    assign wr_uart = w_wr;
    assign wr_data = w_wr_data;
    assign ack     = w_ack;
    assign owner   = reset ? '0 : r_owner;
    assign busy    = !reset && w_locked;
    assign abort   = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  wr_data;
    logic [1:0]  owner;
    logic        busy;
    logic        abort;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .DATA_BITS (8),
        .NUM_REQ   (4),
        .TIMEOUT   (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .data_in (data_in),
        .ack     (ack),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .wr_data (wr_data),
        .owner   (owner),
        .busy    (busy),
        .abort   (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        txf;
        logic [31:0] d;
        logic        ewr;
        logic [7:0]  edat;
        logic [3:0]  eack;
        logic [1:0]  eown;
        logic        ebusy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] ls,
                       input logic txf, input logic [31:0] d, input logic ewr,
                       input logic [7:0] edat, input logic [3:0] eack,
                       input logic [1:0] eown, input logic ebusy);
        vec_t v;
        v.rst = rst; v.req = rq; v.last = ls; v.txf = txf; v.d = d;
        v.ewr = ewr; v.edat = edat; v.eack = eack; v.eown = eown; v.ebusy = ebusy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input logic rst, input logic [3:0] rq, input logic [3:0] ls,
                         input logic txf, input logic [31:0] d);
        @(negedge clk);
        reset   = rst;
        req     = rq;
        last    = ls;
        tx_full = txf;
        data_in = d;
        #1;
    endtask

    // Lanes 3..0 default characters 0x33, 0x22, 0x11, 0x00.
    localparam logic [31:0] D0 = 32'h33221100;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        req     = '0;
        last    = '0;
        tx_full = 1'b0;
        data_in = D0;
        repeat (2) @(posedge clk);

        //   rst req      last     txf data          wr  dat    ack      own   busy
        // reset and first cycle after reset
        add(1, 4'b0000, 4'b0000, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);
        // single burst on lane 2: 0x48 then 0x34 (last)
        add(0, 4'b0100, 4'b0000, 0, 32'h33481100, 0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b0100, 4'b0000, 0, 32'h33481100, 1, 8'h48, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0100, 0, 32'h33341100, 1, 8'h34, 4'b0100, 2'd2, 1);
        // rr_ptr is now 3: all requesting selects lane 3
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd2, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h33, 4'b1000, 2'd3, 1);
        add(0, 4'b0000, 4'b0000, 0, D0,           0, 8'h00, 4'b0000, 2'd3, 0);
        // contention from rr_ptr 0: owners 0,1,2,3,0, one write per grant
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd3, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h00, 4'b0001, 2'd0, 1);
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h11, 4'b0010, 2'd1, 1);
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd1, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h22, 4'b0100, 2'd2, 1);
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd2, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h33, 4'b1000, 2'd3, 1);
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd3, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h00, 4'b0001, 2'd0, 1);
        add(0, 4'b0000, 4'b0000, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);
        // backpressure: owner 1 holds 0x71, tx_full for 5 locked cycles
        add(0, 4'b0010, 4'b0010, 1, 32'h33227100, 0, 8'h00, 4'b0000, 2'd0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0010, 4'b0010, 1, 32'h33227100, 0, 8'h00, 4'b0000, 2'd1, 1);
        add(0, 4'b0010, 4'b0010, 0, 32'h33227100, 1, 8'h71, 4'b0010, 2'd1, 1);
        add(0, 4'b0000, 4'b0000, 0, 32'h33227100, 0, 8'h00, 4'b0000, 2'd1, 0);
        // lock hold: owner 0 mid-burst, lane 3 requesting throughout
        add(0, 4'b0001, 4'b0000, 0, 32'h33221111, 0, 8'h00, 4'b0000, 2'd1, 0);
        add(0, 4'b1001, 4'b0000, 0, 32'h33221111, 1, 8'h11, 4'b0001, 2'd0, 1);
        add(0, 4'b1001, 4'b0000, 0, 32'h3322115A, 1, 8'h5A, 4'b0001, 2'd0, 1);
        add(0, 4'b1000, 4'b0000, 0, 32'h3322115A, 0, 8'h00, 4'b0000, 2'd0, 1);
        add(0, 4'b1001, 4'b0001, 0, 32'h33221112, 1, 8'h12, 4'b0001, 2'd0, 1);
        add(0, 4'b1000, 4'b0000, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b1000, 4'b1000, 0, D0,           1, 8'h33, 4'b1000, 2'd3, 1);
        // move rr_ptr to 2, then start a 4-character burst on lane 2
        add(0, 4'b0010, 4'b0010, 0, 32'h33225500, 0, 8'h00, 4'b0000, 2'd3, 0);
        add(0, 4'b0010, 4'b0010, 0, 32'h33225500, 1, 8'h55, 4'b0010, 2'd1, 1);
        add(0, 4'b0100, 4'b0000, 0, 32'h33C11100, 0, 8'h00, 4'b0000, 2'd1, 0);
        add(0, 4'b0100, 4'b0000, 0, 32'h33C11100, 1, 8'hC1, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0000, 0, 32'h33C21100, 1, 8'hC2, 4'b0100, 2'd2, 1);
        // reset mid-burst: outputs zero, burst abandoned, rr_ptr back to 0
        add(1, 4'b0100, 4'b0000, 0, 32'h33C31100, 0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 0, 32'h33C31100, 0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1111, 0, D0,           1, 8'h00, 4'b0001, 2'd0, 1);
        add(0, 4'b0000, 4'b0000, 0, D0,           0, 8'h00, 4'b0000, 2'd0, 0);

        foreach (tbl[r]) begin
            drive(tbl[r].rst, tbl[r].req, tbl[r].last, tbl[r].txf, tbl[r].d);
            chk("wr_uart", r, 32'(wr_uart), 32'(tbl[r].ewr));
            chk("ack",     r, 32'(ack),     32'(tbl[r].eack));
            chk("owner",   r, 32'(owner),   32'(tbl[r].eown));
            chk("busy",    r, 32'(busy),    32'(tbl[r].ebusy));
            chk("abort",   r, 32'(abort),   32'd0);
            if (tbl[r].ewr)
                chk("wr_data", r, 32'(wr_data), 32'(tbl[r].edat));
        end

        // Stalled lock: rr_ptr is 1, lane 0 grabs the lock then stops
        // requesting while lane 3 waits.
        drive(0, 4'b0001, 4'b0000, 0, D0);
        chk("stall_grant_busy", 100, 32'(busy), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 1; k <= 18; k++) begin
            drive(0, 4'b1000, 4'b0000, 0, D0);
            if (k < 16) begin
                chk("to_busy",  100 + k, 32'(busy),  32'd1);
                chk("to_abort", 100 + k, 32'(abort), 32'd0);
                chk("to_ack",   100 + k, 32'(ack),   32'd0);
            end else if (k == 16) begin
                chk("to_abort_pulse", 100 + k, 32'(abort), 32'd1);
                chk("to_busy",        100 + k, 32'(busy),  32'd1);
            end else if (k == 17) begin
                chk("to_busy_fall", 100 + k, 32'(busy),  32'd0);
                chk("to_abort_end", 100 + k, 32'(abort), 32'd0);
            end else begin
                chk("to_next_owner", 100 + k, 32'(owner), 32'd3);
                chk("to_next_ack",   100 + k, 32'(ack),   32'b1000);
            end
        end
`else
        for (int k = 1; k <= 24; k++) begin
            drive(0, 4'b1000, 4'b0000, 0, D0);
            chk("hold_busy",  100 + k, 32'(busy),    32'd1);
            chk("hold_abort", 100 + k, 32'(abort),   32'd0);
            chk("hold_ack",   100 + k, 32'(ack),     32'd0);
            chk("hold_owner", 100 + k, 32'(owner),   32'd0);
            chk("hold_wr",    100 + k, 32'(wr_uart), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001 Parameter DATA_BITS, default 8: width of one UART character; shall match the UART TX path data width.
- REQ-002 Parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
- REQ-003 Parameter TIMEOUT, default 16: stall-cycle limit for the lock-release timeout; legal range 2..255.
- REQ-004 Port clk, input, 1 bit: single clock; every register is updated on its rising edge.
- REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-006 Port req, input, NUM_REQ bits: requester i has a character valid on its data lane.
- REQ-007 Port last, input, NUM_REQ bits: the character on lane i is the final character of its burst.
- REQ-008 Port data_in, input, NUM_REQ*DATA_BITS bits: lane i occupies bits [i*DATA_BITS +: DATA_BITS].
- REQ-009 Port ack, output, NUM_REQ bits: one-hot, one cycle per pulse; lane i's character was accepted this cycle.
- REQ-010 Port tx_full, input, 1 bit: UART TX FIFO full.
- REQ-011 Port wr_uart, output, 1 bit: write strobe to the UART TX FIFO.
- REQ-012 Port wr_data, output, DATA_BITS bits: character presented to the UART TX FIFO.
- REQ-013 Port owner, output, $clog2(NUM_REQ) bits: index of the requester holding the lock.
- REQ-014 Port busy, output, 1 bit: high while the lock is held.
- REQ-015 Port abort, output, 1 bit: one-cycle pulse when the lock is force-released by the timeout.

Function
- REQ-016 The FSM shall have exactly two states: IDLE and LOCKED.
- REQ-017 IDLE with any req bit set: select the first set bit searching upward from rr_ptr with wrap-around, register it into owner and enter LOCKED on the next edge; nothing is written during the IDLE cycle.
- REQ-018 In LOCKED, wr_uart shall be combinational and equal req[owner] AND NOT tx_full.
- REQ-019 wr_data shall equal lane owner of data_in in every cycle; its value is don't-care when wr_uart is 0.
- REQ-020 ack[owner] shall equal wr_uart, and all other ack bits shall be 0.
- REQ-021 A write with last[owner]=1 shall return the FSM to IDLE and set rr_ptr to owner+1 modulo NUM_REQ; the lock holder shall not re-arbitrate in that same cycle.
- REQ-022 Requests from non-owners shall be ignored while LOCKED; no write shall ever occur for a non-owner.
- REQ-023 With tx_full high, no write shall occur, the owner shall not change and a held character shall not be dropped.
- REQ-024 busy shall be 1 exactly when the FSM is in LOCKED.
- REQ-025 The worst-case wait from a request to its grant shall be NUM_REQ-1 completed bursts.

Reset
- REQ-026 Reset shall set: state IDLE, rr_ptr 0, owner 0, stall counter 0.
- REQ-027 During reset and on the first cycle after it: wr_uart=0, ack=0, busy=0, abort=0.
- REQ-028 Reset asserted mid-burst shall abandon the burst with no further write and no abort pulse.

Configuration
- REQ-029 The feature macro shall be UART_ARB_TIMEOUT_EN.
- REQ-030 With UART_ARB_TIMEOUT_EN defined, the stall counter in LOCKED shall behave as follows:
  - increments on each cycle with req[owner]=0;
  - clears on any write and whenever tx_full is 1;
  - on reaching TIMEOUT, returns the FSM to IDLE, pulses abort for one cycle and sets rr_ptr to owner+1.
- REQ-031 Without UART_ARB_TIMEOUT_EN, the lock shall be held until a last write; abort shall be tied to 0 and no counter logic shall be synthesized.

Verification
- REQ-032 Single burst: req[2] with data 0x48 then 0x34 (last on 0x34), tx_full=0 -> grant after 1 IDLE cycle; wr_uart on 2 consecutive cycles with 0x48, 0x34; ack[2] matches; then IDLE with rr_ptr=3.
- REQ-033 Contention: req=4'b1111 held, single-character bursts, rr_ptr=0 -> owner sequence 0,1,2,3,0; each grant followed by exactly one write.
- REQ-034 Backpressure: owner 1 holds 0x71, tx_full high for 5 cycles -> no wr_uart and no ack during those cycles; 0x71 written once on the first cycle after tx_full falls.
- REQ-035 Lock hold: owner 0 mid-burst, req[3] asserted throughout -> no ack[3] until owner 0 writes with last.
- REQ-036 Timeout (macro on, TIMEOUT=16): owner drops req for 16 cycles without last -> abort pulses, busy falls and the next requester is granted; with the macro off, busy stays 1 indefinitely.
- REQ-037 Reset mid-burst: reset asserted on the cycle after the second character of a 4-character burst -> all outputs 0, rr_ptr=0, and no write of the remaining characters.
